hex_seg_driver: RTL
===================

# hex_seg_driver

Seven-segment output stage that sits directly downstream of the Nios HEX PIO slaves. It takes the 7-bit active-high segment patterns the PIOs hold for all digits and drives the board's active-low HEX pins. On the way it applies global PWM dimming, per-digit blinking and a lamp-test override. All timing comes from an internal prescaled timebase.

## Interface
Parameters:
- NUM_DIGITS, 6, number of 7-segment digits driven
- PRESCALE, 500, clk cycles per timebase tick (100 kHz tick at 50 MHz)
- BLINK_TICKS, 50000, ticks per blink half-period (0.5 s at default)

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- seg_in  in  7*NUM_DIGITS  PIO segment patterns, active-high; digit d at [7d+6:7d], bit 0 = segment a
- blink_mask  in  NUM_DIGITS  1 = digit d blinks
- brightness  in  4  PWM duty; 0 = off, 15 = full on
- lamp_test  in  1  asynchronous button; forces all segments on
- hex_n  out  7*NUM_DIGITS  registered, active-low segment pins
- frame_tick  out  1  one-cycle pulse at each PWM frame wrap

## Operation
- **Input register:** seg_q <= seg_in every cycle. blink_mask is registered alongside it.
- **Prescaler:** pre_cnt counts 0..PRESCALE-1 and wraps. tick = (pre_cnt == PRESCALE-1).
- **PWM counter:** pwm_cnt is 4 bits and increments on tick, wrapping 15 -> 0.
  - frame_tick = tick & (pwm_cnt == 15).
  - bright_q <= brightness only when frame_tick is high, so duty changes take effect only at frame boundaries.
- **Duty:** pwm_on = (bright_q == 15) | (pwm_cnt < bright_q). The lit fraction is bright_q/16, except 15, which is 100 %.
- **Blink counter:** blink_cnt counts ticks 0..BLINK_TICKS-1 and wraps. At each wrap, blink_phase toggles. blink_phase resets to 1 (visible).
- **Digit visibility:** vis[d] = ~blink_mask_q[d] | blink_phase. All blinking digits are in phase.
- **Lamp test:** lamp_test passes through a 2-flop synchronizer to give lt_s.
- **Output, per digit:** hex_n[d] <= ~(lt_s ? 7'h7F : seg_q[d] & {7{pwm_on & vis[d]}}).
- **Lamp-test priority:** lamp test overrides PWM, blink and seg_in.
- **Reset values (asynchronous):**
  - hex_n = all ones (blank); frame_tick = 0.
  - pre_cnt, pwm_cnt and blink_cnt = 0.
  - bright_q = 0, so the display stays dark until the first frame_tick. blink_phase = 1.
  - seg_q = 0; synchronizer flops = 0.
- **Reset asserted mid-frame:** all state returns to the reset values immediately. Nothing is preserved.
- **Simultaneous brightness change and frame_tick:** the new brightness value is captured.
- **No bypass:** brightness 0 with lamp_test low gives a fully blank display regardless of seg_in.

## Timing
- seg_in -> hex_n: 2 clk (input reg + output reg), provided pwm_on & vis.
- lamp_test -> hex_n: 3 clk (2 sync + output reg), both on assertion and on release.
- brightness -> duty: applied at the next frame_tick; visible from the first cycle of the following frame.
- Frame period: 16*PRESCALE clk.
- PWM on-time per frame: bright_q*PRESCALE contiguous clk, beginning at pwm_cnt = 0, delayed by 1 clk through the output reg.
- Blink half-period: BLINK_TICKS*PRESCALE clk.
- frame_tick: exactly 1 clk wide, period 16*PRESCALE.

## Structure
- **Package hex_seg_pkg:**
  - SEG_W = 7, PWM_W = 4
  - SEG_ALL_ON = 7'h7F, SEG_BLANK_N = 7'h7F
  - function for digit slice indexing
- **Sub-module hex_seg_timebase:** holds the prescaler, PWM counter, bright_q, blink counter and blink_phase. It outputs pwm_on, blink_phase and frame_tick.
- **Top (hex_seg_driver):** holds the input/sync registers and a generate loop over digits for gating and the output register.

## Test plan
Bench parameters: NUM_DIGITS=2, PRESCALE=4, BLINK_TICKS=8 (frame = 64 clk, blink half = 32 clk).
- **Reset:** assert reset_n=0 mid-run -> hex_n = 14'h3FFF and frame_tick = 0 immediately; display stays blank until the first frame_tick, 64 clk after release.
- **Static display:** brightness=15, seg_in = {7'h06, 7'h3F} -> after the first frame_tick, hex_n = {7'h79, 7'h40} constant.
- **Dimming:** brightness=4 -> each 64-clk frame shows hex_n[6:0]=7'h40 for exactly 16 clk, then 7'h7F for 48 clk.
- **Brightness changed mid-frame:** change 4 -> 8 mid-frame -> the current frame keeps 16 clk on-time; the next frame has 32 clk on-time.
- **Blink:** blink_mask=2'b01, brightness=15 -> digit 0 alternates 32 clk lit / 32 clk blank starting visible; digit 1 stays steady.
- **Lamp test:** brightness=0, seg_in=0, lamp_test pulsed high for 10 clk -> hex_n = 14'h0000 from cycle 3 through cycle 12, then 14'h3FFF.

Source files
------------

// File: rtl/hex_seg_pkg.sv
// Shared constants and helpers for the seven-segment output stage.
package hex_seg_pkg;

  localparam int SEG_W = 7;
  localparam int PWM_W = 4;

  localparam logic [SEG_W-1:0] SEG_ALL_ON  = 7'h7F;
  localparam logic [SEG_W-1:0] SEG_BLANK_N = 7'h7F;
  localparam logic [PWM_W-1:0] PWM_FULL    = 4'hF;

  // Lowest bit index of digit 'digit' inside a packed segment bus.
  function automatic int seg_lo(input int digit);
    return digit * SEG_W;
  endfunction

endpackage

// File: rtl/hex_seg_timebase.sv
// Prescaled timebase: PWM frame counter with frame-aligned brightness
// capture, plus the shared blink phase used by every blinking digit.
module hex_seg_timebase
  import hex_seg_pkg::*;
#(
  parameter int unsigned PRESCALE    = 500,
  parameter int unsigned BLINK_TICKS = 50000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [PWM_W-1:0] brightness,
  output logic             pwm_on,
  output logic             blink_phase,
  output logic             frame_tick
);

  localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int BLK_W = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_TICKS - 1);

  logic [PRE_W-1:0] r_pre_cnt;
  logic [PWM_W-1:0] r_pwm_cnt;
  logic [PWM_W-1:0] r_bright_q;
  logic [BLK_W-1:0] r_blink_cnt;
  logic             r_blink_phase;
  logic             w_tick;
  logic             w_frame_tick;

  assign w_tick       = (r_pre_cnt == PRE_LAST);
  assign w_frame_tick = w_tick & (r_pwm_cnt == PWM_FULL);

  // Prescaler: free-running 0..PRESCALE-1, one tick per wrap.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    r_pre_cnt <= '0;
    else if (w_tick) r_pre_cnt <= '0;
    else             r_pre_cnt <= r_pre_cnt + PRE_W'(1);
  end

  // PWM position within the 16-tick frame; wraps naturally at 15.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    r_pwm_cnt <= '0;
    else if (w_tick) r_pwm_cnt <= r_pwm_cnt + PWM_W'(1);
  end

  // Brightness is only sampled at the frame wrap so a frame never changes duty half-way.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)          r_bright_q <= '0;
    else if (w_frame_tick) r_bright_q <= brightness;
  end

  // Blink half-period counter; phase starts visible and toggles on each wrap.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b1;
    end else if (w_tick) begin
      if (r_blink_cnt == BLK_LAST) begin
        r_blink_cnt   <= '0;
        r_blink_phase <= ~r_blink_phase;
      end else begin
        r_blink_cnt <= r_blink_cnt + BLK_W'(1);
      end
    end
  end

  // Full scale is a special case so 15 means 100 % rather than 15/16.
  assign pwm_on      = (r_bright_q == PWM_FULL) | (r_pwm_cnt < r_bright_q);
  assign blink_phase = r_blink_phase;
  assign frame_tick  = w_frame_tick;

endmodule

// File: rtl/hex_seg_driver.sv
// HEX output stage: registers the PIO segment patterns, applies PWM dimming,
// per-digit blink and a synchronised lamp test, and drives active-low pins.
module hex_seg_driver
  import hex_seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS  = 6,
  parameter int unsigned PRESCALE    = 500,
  parameter int unsigned BLINK_TICKS = 50000
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [SEG_W*NUM_DIGITS-1:0] seg_in,
  input  logic [NUM_DIGITS-1:0]       blink_mask,
  input  logic [PWM_W-1:0]            brightness,
  input  logic                        lamp_test,
  output logic [SEG_W*NUM_DIGITS-1:0] hex_n,
  output logic                        frame_tick
);

  logic [SEG_W*NUM_DIGITS-1:0] r_seg_q;
  logic [NUM_DIGITS-1:0]       r_mask_q;
  logic [1:0]                  r_lt_sync;
  logic [SEG_W*NUM_DIGITS-1:0] r_hex_n;
  logic                        w_lt_s;
  logic                        w_pwm_on;
  logic                        w_blink_phase;

  // Input capture of the PIO patterns and blink mask.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_seg_q  <= '0;
      r_mask_q <= '0;
    end else begin
      r_seg_q  <= seg_in;
      r_mask_q <= blink_mask;
    end
  end

  // Two-flop synchroniser for the asynchronous lamp-test button.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_lt_sync <= 2'b00;
    else          r_lt_sync <= {r_lt_sync[0], lamp_test};
  end

  assign w_lt_s = r_lt_sync[1];

  hex_seg_timebase #(
    .PRESCALE    (PRESCALE),
    .BLINK_TICKS (BLINK_TICKS)
  ) u_timebase (
    .clk         (clk),
    .reset_n     (reset_n),
    .brightness  (brightness),
    .pwm_on      (w_pwm_on),
    .blink_phase (w_blink_phase),
    .frame_tick  (frame_tick)
  );

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      logic w_enable;
      assign w_enable = w_pwm_on & (~r_mask_q[gi] | w_blink_phase);

      // Output register: lamp test wins over PWM, blink and pattern.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
          r_hex_n[seg_lo(gi) +: SEG_W] <= SEG_BLANK_N;
        else
          r_hex_n[seg_lo(gi) +: SEG_W] <= ~(w_lt_s ? SEG_ALL_ON
                                           : (r_seg_q[seg_lo(gi) +: SEG_W] & {SEG_W{w_enable}}));
      end
    end
  endgenerate

  assign hex_n = r_hex_n;

endmodule
